// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - execute-stage and data-RAM bus bundle for mem_access_unit
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              op_valid;
  logic [3:0]        op_code;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] ram_data_in;
  logic              busy;
  logic              done;
  logic              fault;
  logic              sel_ldr_bus;
  logic [DATA_W-1:0] data_ldr_out;
  logic              ram_en;
  logic              ram_rw_flag;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_out;

  // Pipeline/RAM environment side
  modport master (
    output op_valid, op_code, src1, src2, ram_data_in,
    input  busy, done, fault, sel_ldr_bus, data_ldr_out,
    input  ram_en, ram_rw_flag, ram_addr, ram_data_out
  );

  // Memory access unit side
  modport slave (
    input  op_valid, op_code, src1, src2, ram_data_in,
    output busy, done, fault, sel_ldr_bus, data_ldr_out,
    output ram_en, ram_rw_flag, ram_addr, ram_data_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequential LDR/STR memory-stage controller with wait states
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);
  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              is_ldr_q;
  logic              done_q;
  logic              fault_q;
  logic              sel_q;
  logic              ram_en_q;
  logic              ram_rw_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] ldr_data_q;

  logic mem_op;
  logic op_is_ldr;
  logic out_of_range;

  assign mem_op    = bus.op_valid && ((bus.op_code == OP_LDR) || (bus.op_code == OP_STR));
  assign op_is_ldr = (bus.op_code == OP_LDR);
  assign cnt_d     = cnt_q - CNT_ONE;

  // Any set bit above the RAM address range makes the access illegal
  generate
    if (ADDR_W < DATA_W) begin : g_range
      assign out_of_range = |bus.src1[DATA_W-1:ADDR_W];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Stall while an op is presented in IDLE or in flight; forced low under reset
  assign bus.busy = rst_n && (((state_q == S_IDLE) && mem_op) ||
                              (state_q == S_ACCESS) || (state_q == S_WAIT));

  assign bus.done         = done_q;
  assign bus.fault        = fault_q;
  assign bus.sel_ldr_bus  = sel_q;
  assign bus.data_ldr_out = ldr_data_q;
  assign bus.ram_en       = ram_en_q;
  assign bus.ram_rw_flag  = ram_rw_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_data_out = ram_wdata_q;

  // Access FSM with registered outputs; pulses default low each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_ldr_q    <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      sel_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ldr_data_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      sel_q    <= 1'b0;
      ram_en_q <= 1'b0;
      ram_rw_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            is_ldr_q <= op_is_ldr;
            if (out_of_range) begin
              // Fault skips the RAM entirely; address/data outputs keep old values
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ram_en_q    <= 1'b1;
              ram_rw_q    <= op_is_ldr;
              ram_addr_q  <= bus.src1[ADDR_W-1:0];
              ram_wdata_q <= bus.src2;
              state_q     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          cnt_q <= CNT_LOAD;
          if (WAIT_CYCLES == 0) begin
            done_q  <= 1'b1;
            sel_q   <= is_ldr_q;
            if (is_ldr_q) ldr_data_q <= bus.ram_data_in;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_ONE) begin
            done_q  <= 1'b1;
            sel_q   <= is_ldr_q;
            if (is_ldr_q) ldr_data_q <= bus.ram_data_in;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  logic        clk;
  logic        rst_n;
  logic        tgt;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] ram_data_in;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobe_at = 0;
  int first_strobe = 0;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(16)) bus0 ();
  mem_access_unit_if #(.DATA_W(32), .ADDR_W(16)) bus1 ();

  assign bus0.op_valid    = op_valid & ~tgt;
  assign bus0.op_code     = op_code;
  assign bus0.src1        = src1;
  assign bus0.src2        = src2;
  assign bus0.ram_data_in = ram_data_in;
  assign bus1.op_valid    = op_valid & tgt;
  assign bus1.op_code     = op_code;
  assign bus1.src1        = src1;
  assign bus1.src2        = src2;
  assign bus1.ram_data_in = ram_data_in;

  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  logic        o_busy, o_done, o_fault, o_sel, o_en, o_rw;
  logic [31:0] o_data, o_wdata;
  logic [15:0] o_addr;
  assign o_busy  = tgt ? bus1.busy         : bus0.busy;
  assign o_done  = tgt ? bus1.done         : bus0.done;
  assign o_fault = tgt ? bus1.fault        : bus0.fault;
  assign o_sel   = tgt ? bus1.sel_ldr_bus  : bus0.sel_ldr_bus;
  assign o_en    = tgt ? bus1.ram_en       : bus0.ram_en;
  assign o_rw    = tgt ? bus1.ram_rw_flag  : bus0.ram_rw_flag;
  assign o_data  = tgt ? bus1.data_ldr_out : bus0.data_ldr_out;
  assign o_wdata = tgt ? bus1.ram_data_out : bus0.ram_data_out;
  assign o_addr  = tgt ? bus1.ram_addr     : bus0.ram_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one op and checks every cycle up to and including the done cycle.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input int n, input int strobe_c,
                        input bit exp_fault, input bit exp_sel, input logic [31:0] rd_val,
                        input int rd_c, input logic [31:0] exp_data, input logic [15:0] exp_addr);
    op_valid = 1'b1;
    op_code  = op;
    src1     = s1;
    src2     = s2;
    for (int c = 1; c <= n; c++) begin
      ram_data_in = (c >= rd_c) ? rd_val : 32'h1111_1111;
      @(negedge clk);
      chk($sformatf("%s:busy@%0d", tag, c), {31'd0, o_busy}, {31'd0, c < n});
      chk($sformatf("%s:done@%0d", tag, c), {31'd0, o_done}, {31'd0, c == n});
      chk($sformatf("%s:ram_en@%0d", tag, c), {31'd0, o_en}, {31'd0, c == strobe_c});
      chk($sformatf("%s:fault@%0d", tag, c), {31'd0, o_fault}, {31'd0, (c == n) && exp_fault});
      chk($sformatf("%s:sel@%0d", tag, c), {31'd0, o_sel}, {31'd0, (c == n) && exp_sel});
      if (c == strobe_c) begin
        strobe_at = cyc;
        chk($sformatf("%s:rw", tag), {31'd0, o_rw}, {31'd0, op == OP_LDR});
        chk($sformatf("%s:addr", tag), {16'd0, o_addr}, {16'd0, exp_addr});
        if (op == OP_STR) chk($sformatf("%s:wdata", tag), o_wdata, s2);
      end
      if (c == n) chk($sformatf("%s:data", tag), o_data, exp_data);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tgt = 1'b0; rst_n = 1'b0; op_valid = 1'b0; op_code = 4'hF;
    src1 = '0; src2 = '0; ram_data_in = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst:busy", {31'd0, o_busy}, 32'd0);
    chk("rst:done", {31'd0, o_done}, 32'd0);
    chk("rst:fault", {31'd0, o_fault}, 32'd0);
    chk("rst:sel", {31'd0, o_sel}, 32'd0);
    chk("rst:ram_en", {31'd0, o_en}, 32'd0);
    chk("rst:rw", {31'd0, o_rw}, 32'd1);
    chk("rst:data", o_data, 32'd0);
    chk("rst:addr", {16'd0, o_addr}, 32'd0);
    chk("rst:wdata", o_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // STR accepted in the first cycle out of reset
    run_op("str", OP_STR, 32'h0000_0010, 32'hDEAD_BEEF, 5, 2, 1'b0, 1'b0,
           32'h0, 99, 32'h0, 16'h0010);
    op_valid = 1'b0;
    @(negedge clk);
    chk("str:rw_idle", {31'd0, o_rw}, 32'd1);
    chk("str:addr_hold", {16'd0, o_addr}, 32'h0010);
    chk("str:wdata_hold", o_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // LDR with read data only valid in the last wait cycle
    run_op("ldr", OP_LDR, 32'h0000_0010, 32'h0, 5, 2, 1'b0, 1'b1,
           32'hCAFE_0001, 4, 32'hCAFE_0001, 16'h0010);
    op_valid = 1'b0;
    @(posedge clk); #1;

    // STR leaves the load result alone
    run_op("str2", OP_STR, 32'h0000_0020, 32'h1234_5678, 5, 2, 1'b0, 1'b0,
           32'h0, 99, 32'hCAFE_0001, 16'h0020);
    op_valid = 1'b0;
    @(posedge clk); #1;

    // Out-of-range LDR faults without touching the RAM
    run_op("flt", OP_LDR, 32'h0001_0000, 32'h0, 2, 0, 1'b1, 1'b0,
           32'h5555_5555, 1, 32'hCAFE_0001, 16'h0);
    op_valid = 1'b0;
    @(negedge clk);
    chk("flt:addr_hold", {16'd0, o_addr}, 32'h0020);
    chk("flt:wdata_hold", o_wdata, 32'h1234_5678);
    chk("flt:data_hold", o_data, 32'hCAFE_0001);
    @(posedge clk); #1;

    // Non-memory op codes are ignored
    op_valid = 1'b1; src1 = 32'h10;
    for (int k = 0; k < 6; k++) begin
      op_code = (k < 3) ? 4'b0000 : 4'b1111;
      @(negedge clk);
      chk($sformatf("nop:busy@%0d", k), {31'd0, o_busy}, 32'd0);
      chk($sformatf("nop:done@%0d", k), {31'd0, o_done}, 32'd0);
      chk($sformatf("nop:ram_en@%0d", k), {31'd0, o_en}, 32'd0);
      @(posedge clk); #1;
    end

    // LDR immediately followed by STR
    run_op("b2b_ldr", OP_LDR, 32'h0000_0040, 32'h0, 5, 2, 1'b0, 1'b1,
           32'hA5A5_0002, 4, 32'hA5A5_0002, 16'h0040);
    first_strobe = strobe_at;
    run_op("b2b_str", OP_STR, 32'h0000_0044, 32'h0BAD_F00D, 5, 2, 1'b0, 1'b0,
           32'h0, 99, 32'hA5A5_0002, 16'h0044);
    chk("b2b:strobe_gap", strobe_at - first_strobe, 32'd5);
    op_valid = 1'b0;
    @(posedge clk); #1;

    // Reset asserted during the wait phase of an LDR
    op_valid = 1'b1; op_code = OP_LDR; src1 = 32'h0000_0050; ram_data_in = 32'h7777_7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmid:busy_pre", {31'd0, o_busy}, 32'd1);
    chk("rmid:data_pre", o_data, 32'hA5A5_0002);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid:ram_en", {31'd0, o_en}, 32'd0);
    chk("rmid:busy", {31'd0, o_busy}, 32'd0);
    chk("rmid:done", {31'd0, o_done}, 32'd0);
    chk("rmid:data", o_data, 32'd0);
    chk("rmid:addr", {16'd0, o_addr}, 32'd0);
    chk("rmid:rw", {31'd0, o_rw}, 32'd1);
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rmid:post_done@%0d", k), {31'd0, o_done}, 32'd0);
      chk($sformatf("rmid:post_en@%0d", k), {31'd0, o_en}, 32'd0);
      chk($sformatf("rmid:post_busy@%0d", k), {31'd0, o_busy}, 32'd0);
      @(posedge clk); #1;
    end

    // Zero-wait instance: data sampled on the edge that ends ACCESS
    tgt = 1'b1;
    run_op("w0", OP_LDR, 32'h0000_0030, 32'h0, 3, 2, 1'b0, 1'b1,
           32'hBEEF_0003, 2, 32'hBEEF_0003, 16'h0030);
    op_valid = 1'b0;
    @(negedge clk);
    chk("w0:done_after", {31'd0, o_done}, 32'd0);
    chk("w0:data_hold", o_data, 32'hBEEF_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
